// File: rtl/aes_mix_columns_iter_if.sv
// Handshake bundle for the iterative MixColumns engine: state in, state out, plus busy.
interface aes_mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns: COLS_PER_CYCLE column units sweep the
// 128-bit working state in 4/COLS_PER_CYCLE cycles, then hold it until taken.
module aes_mix_col (
    input  logic        inv,
    input  logic [31:0] col,
    output logic [31:0] res
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] a, x2, x4, x8;

    for (genvar r = 0; r < 4; r++) begin : g_pow
        assign a[r]  = col[31-8*r -: 8];
        assign x2[r] = xt(a[r]);
        assign x4[r] = xt(x2[r]);
        assign x8[r] = xt(x4[r]);
    end

    // Each output row uses the same coefficients rotated by its row number.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        logic [7:0] fw, iv;
        assign fw = x2[r] ^ (x2[R1] ^ a[R1]) ^ a[R2] ^ a[R3];
        assign iv = (x8[r] ^ x4[r] ^ x2[r]) ^ (x8[R1] ^ x2[R1] ^ a[R1])
                  ^ (x8[R2] ^ x4[R2] ^ a[R2]) ^ (x8[R3] ^ a[R3]);
        assign res[31-8*r -: 8] = inv ? iv : fw;
    end
endmodule

module aes_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_mix_columns_iter_if.slave bus
);
    localparam int N  = 4 / COLS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                         st, st_nx;
    logic [3:0][31:0]               w;      // w[3] is column 0
    logic                           mode;
    logic [CW-1:0]                  cnt;
    logic [COLS_PER_CYCLE-1:0][31:0] grp_out;
    logic [1:0]                     cidx [COLS_PER_CYCLE];

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
        assign cidx[j] = 2'(int'(cnt) * COLS_PER_CYCLE + j);
        aes_mix_col u_col (
            .inv (mode),
            .col (w[~cidx[j]]),
            .res (grp_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            w    <= '0;
            mode <= 1'b0;
            cnt  <= '0;
        end else begin
            st <= st_nx;
            case (st)
                IDLE: if (bus.in_valid) begin
                    w    <= bus.in_state;
                    mode <= bus.in_inv;
                    cnt  <= '0;
                end
                CALC: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++) w[~cidx[j]] <= grp_out[j];
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        st_nx         = st;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.out_state = w;
        case (st)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) st_nx = CALC;
            end
            CALC: if (cnt == CW'(N - 1)) st_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed and random round-trip checks of the MixColumns engine at 1, 2 and 4 columns per cycle.
module tb_aes_mix_columns_iter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    aes_mix_columns_iter_if if1 ();
    aes_mix_columns_iter_if if2 ();
    aes_mix_columns_iter_if if4 ();

    aes_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    aes_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    aes_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of the xtime-chain structure.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [7:0] cf [4];
        logic [7:0] a [4];
        logic [7:0] r;
        logic [127:0] o;
        o = '0;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int rw = 0; rw < 4; rw++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) r = r ^ gm(a[(rw+k)%4], cf[k]);
                o[127-32*c-8*rw -: 8] = r;
            end
        end
        return o;
    endfunction

    task automatic run_all(input logic [127:0] s, input logic inv,
                           output logic [127:0] r1, output logic [127:0] r2, output logic [127:0] r4);
        int t;
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_state = s; if1.in_inv = inv; if1.out_ready = 1'b0;
        if2.in_valid = 1'b1; if2.in_state = s; if2.in_inv = inv; if2.out_ready = 1'b0;
        if4.in_valid = 1'b1; if4.in_state = s; if4.in_inv = inv; if4.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        if1.in_valid = 1'b0; if2.in_valid = 1'b0; if4.in_valid = 1'b0;
        t = 0;
        while (!(if1.out_valid && if2.out_valid && if4.out_valid) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rt_all_valid", {127'd0, if1.out_valid & if2.out_valid & if4.out_valid}, 128'd1);
        r1 = if1.out_state; r2 = if2.out_state; r4 = if4.out_state;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0; if2.out_ready = 1'b0; if4.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] s, f1, f2, f4, b1, b2, b4;
        int lat, lows;

        if1.in_valid = 0; if1.in_state = '0; if1.in_inv = 0; if1.out_ready = 0;
        if2.in_valid = 0; if2.in_state = '0; if2.in_inv = 0; if2.out_ready = 0;
        if4.in_valid = 0; if4.in_state = '0; if4.in_inv = 0; if4.out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {127'd0, if1.in_ready & if2.in_ready & if4.in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, if1.out_valid | if2.out_valid | if4.out_valid}, 128'd0);
        chk("rst_busy",      {127'd0, if1.busy | if2.busy | if4.busy}, 128'd0);
        chk("rst_state",     if1.out_state | if2.out_state | if4.out_state, 128'h0);
        rst_n = 1'b1;

        // Forward, one column per cycle: latency and in_ready window
        @(negedge clk);
        if1.in_valid = 1; if1.in_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        if1.in_inv = 0; if1.out_ready = 1;
        @(posedge clk); @(negedge clk);
        if1.in_valid = 0;
        lat = 0; lows = 0;
        while (!if1.out_valid && lat < 20) begin
            if (!if1.in_ready) lows++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        if (!if1.in_ready) lows++;
        chk("fwd1_latency", 128'(lat), 128'd4);
        chk("fwd1_state", if1.out_state, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        @(posedge clk); @(negedge clk);
        if (!if1.in_ready) lows++;
        chk("fwd1_ready_lows", 128'(lows), 128'd5);
        chk("fwd1_ready_back", {127'd0, if1.in_ready}, 128'd1);

        // Inverse, four columns per cycle
        if4.in_valid = 1; if4.in_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        if4.in_inv = 1; if4.out_ready = 1;
        @(posedge clk); @(negedge clk);
        if4.in_valid = 0;
        chk("inv4_not_yet", {127'd0, if4.out_valid}, 128'd0);
        @(posedge clk); @(negedge clk);
        chk("inv4_valid", {127'd0, if4.out_valid}, 128'd1);
        chk("inv4_state", if4.out_state, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        @(posedge clk); @(negedge clk);

        // Backpressure, two columns per cycle, with a second request waiting
        if2.in_valid = 1; if2.in_state = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        if2.in_inv = 0; if2.out_ready = 0;
        @(posedge clk); @(negedge clk);
        if2.in_state = 128'hc6c6c6c6_01010101_db135345_f20a225c;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("bp_valid", {127'd0, if2.out_valid}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_state", if2.out_state, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
            chk("bp_hold_ready", {127'd0, if2.in_ready}, 128'd0);
            @(posedge clk); @(negedge clk);
        end
        if2.out_ready = 1;
        @(posedge clk); @(negedge clk);
        chk("bp_released_idle", {127'd0, if2.in_ready & ~if2.busy}, 128'd1);
        @(posedge clk); @(negedge clk);
        if2.in_valid = 0;
        chk("bp_second_accepted", {127'd0, if2.busy}, 128'd1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("bp_second_state", if2.out_state, 128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d);
        @(posedge clk); @(negedge clk);

        // Mode latching: in_inv toggles while calculating
        if1.in_valid = 1; if1.in_state = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        if1.in_inv = 0; if1.out_ready = 0;
        @(posedge clk); @(negedge clk);
        if1.in_valid = 0;
        lat = 0;
        while (!if1.out_valid && lat < 20) begin
            if1.in_inv = ~if1.in_inv;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("latch_state", if1.out_state, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
        if1.in_inv = 0; if1.out_ready = 1;
        @(posedge clk); @(negedge clk);

        // Reset after two calc cycles
        if1.in_valid = 1; if1.in_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        if1.in_inv = 0; if1.out_ready = 1;
        @(posedge clk); @(negedge clk);
        if1.in_valid = 0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 0;
        #1;
        chk("midrst_ready", {127'd0, if1.in_ready}, 128'd1);
        chk("midrst_busy_valid", {126'd0, if1.busy, if1.out_valid}, 128'd0);
        chk("midrst_state", if1.out_state, 128'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        if1.in_valid = 1; if1.in_state = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        if1.out_ready = 0;
        @(posedge clk); @(negedge clk);
        if1.in_valid = 0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("postrst_valid", {127'd0, if1.out_valid}, 128'd1);
        chk("postrst_state", if1.out_state, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
        if1.out_ready = 1;
        @(posedge clk); @(negedge clk);
        if1.out_ready = 0;

        // Random round trips on all three widths
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_all(s, 1'b0, f1, f2, f4);
            chk("rt_fwd1", f1, mix(s, 1'b0));
            chk("rt_fwd2", f2, mix(s, 1'b0));
            chk("rt_fwd4", f4, mix(s, 1'b0));
            run_all(f1, 1'b1, b1, b2, b4);
            chk("rt_inv1", b1, s);
            chk("rt_inv2", b2, s);
            chk("rt_inv4", b4, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
